// File: rtl/cache_line_adapter_if.sv
// Bundle of controller-side line requests and memory-side beat handshake for cache_line_adapter.
// slave: the adapter's view; master: the surrounding controller/memory view.
interface cache_line_adapter_if #(
   parameter int unsigned WORDS_PER_LINE = 8,
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32
);
   localparam int unsigned LINE_W = WORDS_PER_LINE * DATA_W;

   logic                cl_read;
   logic                cl_write;
   logic [ADDR_W-1:0]   cl_addr;
   logic [LINE_W-1:0]   cl_wdata;
   logic [LINE_W-1:0]   cl_rdata;
   logic                cl_busy;

   logic                mem_req;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W-1:0]   mem_rdata;
   logic                mem_ack;

   modport slave (
      input  cl_read, cl_write, cl_addr, cl_wdata, mem_rdata, mem_ack,
      output cl_rdata, cl_busy, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output cl_read, cl_write, cl_addr, cl_wdata, mem_rdata, mem_ack,
      input  cl_rdata, cl_busy, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/cache_line_adapter.sv
// Splits cache line refills/writebacks into word bursts on a req/ack memory port.
// Define CL_WB_SNAPSHOT_EN to copy the victim line at acceptance instead of reading cl_wdata live.
module cache_line_adapter #(
   parameter int unsigned WORDS_PER_LINE = 8,
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32
) (
   input  logic CLK,
   input  logic RST_N,
   cache_line_adapter_if.slave bus
);
   localparam int unsigned BEAT_W = $clog2(WORDS_PER_LINE);
   localparam int unsigned BYTES  = DATA_W / 8;
   localparam int unsigned OFF_W  = $clog2(WORDS_PER_LINE * BYTES);
   localparam int unsigned LINE_W = WORDS_PER_LINE * DATA_W;

   typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

   state_t              state_q, state_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LINE_W-1:0]   rdata_q, rdata_d;
   logic [LINE_W-1:0]   wsrc;
   logic [DATA_W-1:0]   word_c;
   logic [ADDR_W-1:0]   base_c;
   logic                last_c;
   logic                addr_unused;

   // Offset bits inside the line are discarded by alignment.
   assign addr_unused = ^bus.cl_addr[OFF_W-1:0];
   assign base_c      = {bus.cl_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
   assign last_c      = (beat_q == BEAT_W'(WORDS_PER_LINE - 1));

`ifdef CL_WB_SNAPSHOT_EN
   logic [LINE_W-1:0]   snap_q, snap_d;
   assign wsrc = snap_q;
`else
   assign wsrc = bus.cl_wdata;
`endif

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= IDLE;
         beat_q  <= '0;
         addr_q  <= '0;
         rdata_q <= '0;
`ifdef CL_WB_SNAPSHOT_EN
         snap_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         addr_q  <= addr_d;
         rdata_q <= rdata_d;
`ifdef CL_WB_SNAPSHOT_EN
         snap_q  <= snap_d;
`endif
      end
   end

   // Next-state: accept in IDLE (write beats read), advance one word per acked beat.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      addr_d  = addr_q;
      rdata_d = rdata_q;
`ifdef CL_WB_SNAPSHOT_EN
      snap_d  = snap_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.cl_write) begin
               state_d = WRITE;
               beat_d  = '0;
               addr_d  = base_c;
`ifdef CL_WB_SNAPSHOT_EN
               snap_d  = bus.cl_wdata;
`endif
            end else if (bus.cl_read) begin
               state_d = READ;
               beat_d  = '0;
               addr_d  = base_c;
            end
         end
         WRITE, READ: begin
            if (bus.mem_ack) begin
               if (state_q == READ) begin
                  for (int k = 0; k < int'(WORDS_PER_LINE); k++) begin
                     if (beat_q == BEAT_W'(k)) rdata_d[k*DATA_W +: DATA_W] = bus.mem_rdata;
                  end
               end
               if (last_c) begin
                  state_d = IDLE;
                  beat_d  = '0;
               end else begin
                  beat_d  = beat_q + BEAT_W'(1);
                  addr_d  = addr_q + ADDR_W'(BYTES);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Word select for the current write beat.
   always_comb begin
      word_c = '0;
      for (int k = 0; k < int'(WORDS_PER_LINE); k++) begin
         if (beat_q == BEAT_W'(k)) word_c = wsrc[k*DATA_W +: DATA_W];
      end
   end

   assign bus.cl_busy   = (state_q != IDLE);
   assign bus.mem_req   = (state_q != IDLE);
   assign bus.mem_we    = (state_q == WRITE);
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = (state_q != IDLE) ? word_c : '0;
   assign bus.cl_rdata  = rdata_q;

endmodule

// File: tb/tb_cache_line_adapter.sv
// Randomised self-checking bench for cache_line_adapter against a transaction-level line model.
module tb_cache_line_adapter;
   localparam int unsigned W  = 8;
   localparam int unsigned A  = 32;
   localparam int unsigned D  = 32;
   localparam int unsigned B  = D / 8;
   localparam int unsigned LW = W * D;

   typedef struct {
      bit             we;
      logic [A-1:0]   addr;
      logic [D-1:0]   data;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cache_line_adapter_if #(.WORDS_PER_LINE(W), .ADDR_W(A), .DATA_W(D)) bus ();

   cache_line_adapter #(.WORDS_PER_LINE(W), .ADDR_W(A), .DATA_W(D)) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus.slave)
   );

   int n_checks = 0;
   int n_err    = 0;

   // Model: one outstanding line transfer, described by kind/base/words done.
   bit           m_active = 1'b0;
   bit           m_wr     = 1'b0;
   logic [A-1:0] m_base   = '0;
   int           m_k      = 0;
   logic [D-1:0] m_rd  [W];
   logic [D-1:0] m_src [W];
   bit           chk_en = 1'b0;

   beat_t        blog[$];
   int           busy_cycles = 0;
   int           ack_mode = 0;
   bit           pat_rdata = 1'b0;
   int           acnt = 0;

   task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [LW-1:0] model_line();
      logic [LW-1:0] v;
      for (int k = 0; k < int'(W); k++) v[k*D +: D] = m_rd[k];
      return v;
   endfunction

   initial begin
      for (int k = 0; k < int'(W); k++) begin
         m_rd[k]  = '0;
         m_src[k] = '0;
      end
   end

   // Model update on the same edge the DUT samples.
   always @(posedge clk) begin
      if (!rst_n) begin
         m_active = 1'b0;
         m_k      = 0;
         for (int k = 0; k < int'(W); k++) m_rd[k] = '0;
         chk_en   = 1'b1;
      end else if (!m_active) begin
         if (bus.cl_write || bus.cl_read) begin
            m_active = 1'b1;
            m_wr     = bus.cl_write;
            m_base   = bus.cl_addr & ~A'(W * B - 1);
            m_k      = 0;
            for (int k = 0; k < int'(W); k++) m_src[k] = bus.cl_wdata[k*D +: D];
         end
      end else if (bus.mem_ack) begin
         if (!m_wr) m_rd[m_k] = bus.mem_rdata;
         m_k++;
         if (m_k == int'(W)) m_active = 1'b0;
      end
   end

   // Compare outputs mid-cycle against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         logic [D-1:0] exp_w;
         chk("busy", LW'(bus.cl_busy), LW'(m_active));
         chk("req", LW'(bus.mem_req), LW'(m_active));
         chk("we", LW'(bus.mem_we), LW'(m_active && m_wr));
         chk("cl_rdata", bus.cl_rdata, model_line());
         if (m_active) begin
            busy_cycles++;
            chk("mem_addr", LW'(bus.mem_addr), LW'(m_base + A'(m_k * int'(B))));
`ifdef CL_WB_SNAPSHOT_EN
            exp_w = m_src[m_k];
`else
            exp_w = bus.cl_wdata[m_k*D +: D];
`endif
            if (m_wr) chk("mem_wdata", LW'(bus.mem_wdata), LW'(exp_w));
            if (bus.mem_ack) blog.push_back('{we: m_wr, addr: bus.mem_addr, data: bus.mem_wdata});
         end
      end
   end

   // Memory responder: ack policy plus read data.
   always @(posedge clk) begin
      #1;
      if (bus.cl_busy) acnt++;
      else acnt = 0;
      case (ack_mode)
         0:       bus.mem_ack = 1'b1;
         1:       bus.mem_ack = (acnt != 0) && (acnt % 3 == 0);
         default: bus.mem_ack = 1'($urandom_range(0, 1));
      endcase
      bus.mem_rdata = pat_rdata ? D'(32'hA0 + m_k) : D'($urandom);
   end

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(input bit rd, input bit wr, input logic [A-1:0] addr, input logic [LW-1:0] wd);
      bus.cl_read  = rd;
      bus.cl_write = wr;
      bus.cl_addr  = addr;
      bus.cl_wdata = wd;
      step();
      bus.cl_read  = 1'b0;
      bus.cl_write = 1'b0;
   endtask

   task automatic wait_idle();
      int i = 0;
      while (bus.cl_busy && i < 400) begin
         step();
         i++;
      end
      if (bus.cl_busy) begin
         n_checks++;
         n_err++;
         $display("FAIL wait_idle: busy still %0b after %0d cycles", bus.cl_busy, i);
      end
   endtask

   function automatic logic [LW-1:0] ramp_line(input logic [D-1:0] start);
      logic [LW-1:0] v;
      for (int k = 0; k < int'(W); k++) v[k*D +: D] = start + D'(k);
      return v;
   endfunction

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] v;
      for (int k = 0; k < int'(W); k++) v[k*D +: D] = D'($urandom);
      return v;
   endfunction

   initial begin
      logic [LW-1:0] wl;
      logic [D-1:0]  exp_snap;
      int            n_rd;
      int            i;

      bus.cl_read  = 1'b0;
      bus.cl_write = 1'b0;
      bus.cl_addr  = '0;
      bus.cl_wdata = '0;
      bus.mem_ack  = 1'b0;
      bus.mem_rdata = '0;

      // Reset values
      rst_n = 1'b0;
      step(3);
      chk("rst_busy", LW'(bus.cl_busy), LW'(0));
      chk("rst_req", LW'(bus.mem_req), LW'(0));
      chk("rst_addr", LW'(bus.mem_addr), LW'(0));
      chk("rst_wdata", LW'(bus.mem_wdata), LW'(0));
      chk("rst_rdata", bus.cl_rdata, LW'(0));
      rst_n = 1'b1;
      step(2);

      // Refill 0x1004, ack every cycle
      ack_mode = 0; pat_rdata = 1'b1;
      blog.delete(); busy_cycles = 0;
      pulse(1'b1, 1'b0, 32'h1004, '0);
      chk("t1_req_cycle1", LW'(bus.mem_req), LW'(1));
      chk("t1_addr_cycle1", LW'(bus.mem_addr), LW'(32'h1000));
      wait_idle();
      chk("t1_beats", LW'(blog.size()), LW'(8));
      chk("t1_first_addr", LW'(blog[0].addr), LW'(32'h1000));
      chk("t1_last_addr", LW'(blog[7].addr), LW'(32'h101C));
      chk("t1_busy_len", LW'(busy_cycles), LW'(8));
      chk("t1_line", bus.cl_rdata, ramp_line(32'hA0));

      // Refill with ack every third cycle
      step(2);
      ack_mode = 1;
      blog.delete(); busy_cycles = 0;
      pulse(1'b1, 1'b0, 32'h3008, '0);
      wait_idle();
      chk("t2_busy_len", LW'(busy_cycles), LW'(24));
      chk("t2_beats", LW'(blog.size()), LW'(8));
      chk("t2_line", bus.cl_rdata, ramp_line(32'hA0));

      // Writeback 0x2000, immediate ack
      step(2);
      ack_mode = 0;
      blog.delete(); busy_cycles = 0;
      pulse(1'b0, 1'b1, 32'h2000, ramp_line(32'hB0));
      wait_idle();
      chk("t3_beats", LW'(blog.size()), LW'(8));
      for (int k = 0; k < int'(W); k++) begin
         chk("t3_we", LW'(blog[k].we), LW'(1));
         chk("t3_addr", LW'(blog[k].addr), LW'(32'h2000 + 4 * k));
         chk("t3_data", LW'(blog[k].data), LW'(32'hB0 + k));
      end
      chk("t3_rdata_kept", bus.cl_rdata, ramp_line(32'hA0));

      // Writeback then refill on first busy-low cycle; stray read mid-burst ignored
      step(2);
      pat_rdata = 1'b0;
      blog.delete();
      pulse(1'b0, 1'b1, 32'h5000, rand_line());
      wait_idle();
      chk("t4_req_idle_gap", LW'(bus.mem_req), LW'(0));
      pulse(1'b1, 1'b0, 32'h6000, bus.cl_wdata);
      chk("t4_req_next", LW'(bus.mem_req), LW'(1));
      chk("t4_we_next", LW'(bus.mem_we), LW'(0));
      step(3);
      pulse(1'b1, 1'b0, 32'h7000, bus.cl_wdata);
      wait_idle();
      step(5);
      chk("t4_no_queue", LW'(bus.cl_busy), LW'(0));
      n_rd = 0;
      foreach (blog[j]) if (!blog[j].we) n_rd++;
      chk("t4_read_beats", LW'(n_rd), LW'(8));
      chk("t4_read_base", LW'(blog[8].addr), LW'(32'h6000));

      // Reset during beat 4 of a read
      step(2);
      pulse(1'b1, 1'b0, 32'h1000, '0);
      i = 0;
      while (m_k != 4 && i < 50) begin
         step();
         i++;
      end
      chk("t5_reached_beat4", LW'(m_k), LW'(4));
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("t5_busy", LW'(bus.cl_busy), LW'(0));
      chk("t5_req", LW'(bus.mem_req), LW'(0));
      chk("t5_rdata", bus.cl_rdata, LW'(0));
      chk("t5_addr", LW'(bus.mem_addr), LW'(0));
      step(4);
      chk("t5_late_ack_busy", LW'(bus.cl_busy), LW'(0));
      chk("t5_late_ack_rdata", bus.cl_rdata, LW'(0));

      // Victim line changes after acceptance
      blog.delete();
      pulse(1'b0, 1'b1, 32'h4000, ramp_line(32'hB0));
      bus.cl_wdata = '1;
      wait_idle();
      chk("t6_beats", LW'(blog.size()), LW'(8));
      for (int k = 0; k < int'(W); k++) begin
`ifdef CL_WB_SNAPSHOT_EN
         exp_snap = D'(32'hB0 + k);
`else
         exp_snap = '1;
`endif
         chk("t6_data", LW'(blog[k].data), LW'(exp_snap));
      end

      // Random traffic with random ack gaps
      ack_mode = 2;
      for (int t = 0; t < 40; t++) begin
         int op;
         step($urandom_range(0, 3));
         op = $urandom_range(0, 3);
         wl = rand_line();
         pulse(op == 0 || op >= 2, op == 1 || op == 2, A'($urandom), wl);
         if (op == 3) begin
            step($urandom_range(0, 2));
            pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), A'($urandom), wl);
         end
         wait_idle();
      end
      step(3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
